keypad_scanner: RTL and testbench

Matrix-keypad front end for the digital lock: scans a 4x4 active-low keypad, synchronises and debounces the row inputs, and emits exactly one single-cycle, non-zero 4-bit key code per physical press. It sits directly upstream of the lock FSM, which samples `KEY` every cycle and treats any non-zero value as a new digit. A held or bouncing key must therefore never produce more than one pulse unless auto-repeat is compiled in. Key 15 is reserved as a CLEAR key.

---
 rtl/keypad_scanner.sv | 184 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scanner: 4x4 active-low keypad scanner with synchroniser, debounce   |
// | and one-pulse-per-press key codes. Optional macro: KEYPAD_AUTOREPEAT_EN.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY,
  output logic       CLEAR,
  output logic       KEY_HELD
);

  localparam int c_DWELL_W = $clog2(SCAN_DWELL) + 1;
  localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DWELL - 1);
  localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_EMIT     = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  // The sync delay means a dwell shorter than 3 samples the previous column.
  generate
    if (SCAN_DWELL < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
      $error("keypad_scanner: illegal parameter value");
    end
  endgenerate

  function automatic logic [1:0] f_enc(input logic [3:0] i_oh);
    case (i_oh)
      4'b0010: f_enc = 2'd1;
      4'b0100: f_enc = 2'd2;
      4'b1000: f_enc = 2'd3;
      default: f_enc = 2'd0;
    endcase
  endfunction

  state_t                r_state;
  logic [3:0]            r_row_meta;
  logic [3:0]            r_row_s;
  logic [3:0]            r_col_oh;
  logic [c_DWELL_W-1:0]  r_dwell;
  logic [c_DB_W-1:0]     r_cnt;
  logic [3:0]            r_pat;
  logic [3:0]            r_idx;
  logic [3:0]            r_key;
  logic                  r_clear;
  logic                  r_held;

  logic [3:0] w_row_low;
  logic       w_single;
  logic [3:0] w_col_rot;
  logic [3:0] w_idx;
  logic       w_is_clear;
  logic [3:0] w_key_code;

  assign w_row_low  = ~r_row_s;
  assign w_single   = (w_row_low != 4'd0) && ((w_row_low & (w_row_low - 4'd1)) == 4'd0);
  assign w_col_rot  = {r_col_oh[2:0], r_col_oh[3]};
  assign w_idx      = {f_enc(w_row_low), f_enc(r_col_oh)};
  assign w_is_clear = (r_idx == 4'hF);
  assign w_key_code = w_is_clear ? 4'd0 : r_idx + 4'd1;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int c_REP_W = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);
  logic [c_REP_W-1:0] r_rep;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_SCAN;
      r_row_meta <= 4'hF;
      r_row_s    <= 4'hF;
      r_col_oh   <= 4'b0001;
      r_dwell    <= '0;
      r_cnt      <= '0;
      r_pat      <= 4'hF;
      r_idx      <= 4'd0;
      r_key      <= 4'd0;
      r_clear    <= 1'b0;
      r_held     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep      <= '0;
`endif
    end else begin
      r_row_meta <= ROW;
      r_row_s    <= r_row_meta;
      r_key      <= 4'd0;
      r_clear    <= 1'b0;
      case (r_state)
        S_SCAN: begin
          if (r_dwell == c_DWELL_LAST) begin
            r_dwell <= '0;
            if (w_single) begin
              r_pat   <= r_row_s;
              r_idx   <= w_idx;
              r_cnt   <= '0;
              r_state <= S_DEBOUNCE;
            end else begin
              r_col_oh <= w_col_rot;
            end
          end else begin
            r_dwell <= r_dwell + c_DWELL_W'(1);
          end
        end
        S_DEBOUNCE: begin
          if (r_row_s == r_pat) begin
            if (r_cnt == c_DB_LAST) begin
              r_state <= S_EMIT;
              r_key   <= w_key_code;
              r_clear <= w_is_clear;
              r_held  <= 1'b1;
              r_cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              r_rep   <= '0;
`endif
            end else begin
              r_cnt <= r_cnt + c_DB_W'(1);
            end
          end else begin
            r_state  <= S_SCAN;
            r_col_oh <= w_col_rot;
            r_dwell  <= '0;
          end
        end
        S_EMIT: begin
          r_state <= S_HOLD;
          r_cnt   <= '0;
        end
        default: begin
          // Release is only accepted after an unbroken all-high run.
          if (r_row_s == 4'hF) begin
            if (r_cnt == c_DB_LAST) begin
              r_state  <= S_SCAN;
              r_col_oh <= 4'b0001;
              r_dwell  <= '0;
              r_held   <= 1'b0;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + c_DB_W'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end
      endcase
`ifdef KEYPAD_AUTOREPEAT_EN
      // Repeat phase runs from the EMIT cycle while the latched key stays down.
      if (r_state == S_EMIT || r_state == S_HOLD) begin
        if (r_row_s == 4'hF) begin
          r_rep <= '0;
        end else if (r_row_s == r_pat) begin
          if (r_rep == c_REP_LAST) begin
            r_rep   <= '0;
            r_key   <= w_key_code;
            r_clear <= w_is_clear;
          end else begin
            r_rep <= r_rep + c_REP_W'(1);
          end
        end
      end
`endif
    end
  end

  assign COL      = ~r_col_oh;
  assign KEY      = r_key;
  assign CLEAR    = r_clear;
  assign KEY_HELD = r_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_keypad_scanner: directed self-checking bench for keypad_scanner with a   |
// | behavioural 4x4 keypad model. Honours KEYPAD_AUTOREPEAT_EN.                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] w_row;
  logic [3:0] w_col;
  logic [3:0] w_key;
  logic       w_clear;
  logic       w_held;
  logic [15:0] keys = 16'd0;

  int checks = 0;
  int errors = 0;
  int cyc    = -1;
  int n_pulse = 0;
  int viol   = 0;
  bit prev_pulse = 1'b0;
  int         pulse_cyc [8];
  logic [3:0] pulse_key [8];
  logic       pulse_clr [8];

  keypad_scanner #(.SCAN_DWELL(4), .DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(64)) dut (
    .clock    (clk),
    .reset    (rst),
    .ROW      (w_row),
    .COL      (w_col),
    .KEY      (w_key),
    .CLEAR    (w_clear),
    .KEY_HELD (w_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    w_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && w_col[c] === 1'b0) w_row[r] = 1'b0;
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (w_key !== 4'd0 || w_clear !== 1'b0) begin
      if (n_pulse < 8) begin
        pulse_cyc[n_pulse] = cyc;
        pulse_key[n_pulse] = w_key;
        pulse_clr[n_pulse] = w_clear;
      end
      n_pulse++;
      if (prev_pulse || (w_key !== 4'd0 && w_clear === 1'b1)) viol++;
      prev_pulse = 1'b1;
    end else begin
      prev_pulse = 1'b0;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = -1;
    n_pulse = 0;
    prev_pulse = 1'b0;
  endtask

  task automatic test_reset();
    keys = 16'd0;
    do_reset();
    run_to(0);
    checks++; if (w_col !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", w_col); end
    checks++; if (w_key !== 4'd0 || w_clear !== 1'b0 || w_held !== 1'b0) begin
      errors++; $display("FAIL reset_outs got key=%0d clr=%b held=%b want 0/0/0", w_key, w_clear, w_held); end
    run_to(4);
    checks++; if (w_col !== 4'b1101) begin errors++; $display("FAIL scan_col1 got %b want 1101", w_col); end
    run_to(12);
    checks++; if (w_col !== 4'b0111) begin errors++; $display("FAIL scan_col3 got %b want 0111", w_col); end
    run_to(16);
    checks++; if (w_col !== 4'b1110) begin errors++; $display("FAIL scan_wrap got %b want 1110", w_col); end
  endtask

  // Key 6 (row 1, col 2): sampled at cycle 11, KEY at 11+16+1.
  task automatic test_clean_press();
    keys = 16'd0; keys[6] = 1'b1;
    do_reset();
    run_to(27);
    checks++; if (w_held !== 1'b0) begin errors++; $display("FAIL clean_held_early got %b want 0", w_held); end
    run_to(28);
    checks++; if (w_key !== 4'd7 || w_held !== 1'b1) begin
      errors++; $display("FAIL clean_emit got key=%0d held=%b want 7/1", w_key, w_held); end
    run_to(199);
    checks++; if (n_pulse !== 1 || pulse_cyc[0] !== 28) begin
      errors++; $display("FAIL clean_single got n=%0d at %0d want 1 at 28", n_pulse, pulse_cyc[0]); end
    checks++; if (w_col !== 4'b1011) begin errors++; $display("FAIL clean_col_frozen got %b want 1011", w_col); end
    keys = 16'd0;
    run_to(216);
    checks++; if (w_held !== 1'b1) begin errors++; $display("FAIL clean_held_pre_release got %b want 1", w_held); end
    run_to(217);
    checks++; if (w_held !== 1'b0 || w_col !== 4'b1110) begin
      errors++; $display("FAIL clean_release got held=%b col=%b want 0/1110", w_held, w_col); end
    run_to(240);
    checks++; if (n_pulse !== 1) begin errors++; $display("FAIL clean_no_second got %0d want 1", n_pulse); end
  endtask

  task automatic test_bounce();
    int changes = 0;
    logic [3:0] prev_col;
    keys = 16'd0;
    do_reset();
    run_to(0);
    prev_col = w_col;
    for (int i = 0; i < 100; i++) begin
      keys[0] = ((i % 6) < 5);
      tick();
      if (w_col !== prev_col) changes++;
      prev_col = w_col;
    end
    keys = 16'd0;
    checks++; if (n_pulse !== 0 || w_held !== 1'b0) begin
      errors++; $display("FAIL bounce_no_key got n=%0d held=%b want 0/0", n_pulse, w_held); end
    checks++; if (changes < 10) begin errors++; $display("FAIL bounce_rotate got %0d col changes want >=10", changes); end
  endtask

  // Key 15 (row 3, col 3): sampled at cycle 15, CLEAR at 32.
  task automatic test_clear_key();
    keys = 16'd0; keys[15] = 1'b1;
    do_reset();
    run_to(60);
    checks++; if (n_pulse !== 1 || pulse_cyc[0] !== 32 || pulse_clr[0] !== 1'b1 || pulse_key[0] !== 4'd0) begin
      errors++; $display("FAIL clear_pulse got n=%0d at %0d clr=%b key=%0d want 1 at 32 clr=1 key=0",
                         n_pulse, pulse_cyc[0], pulse_clr[0], pulse_key[0]); end
    checks++; if (w_held !== 1'b1) begin errors++; $display("FAIL clear_held got %b want 1", w_held); end
    keys = 16'd0;
    run_to(100);
  endtask

  task automatic test_ghosting();
    keys = 16'd0; keys[1] = 1'b1; keys[9] = 1'b1;
    do_reset();
    run_to(22);
    checks++; if (w_col !== 4'b1101) begin errors++; $display("FAIL ghost_col22 got %b want 1101", w_col); end
    run_to(99);
    checks++; if (n_pulse !== 0 || w_held !== 1'b0 || w_col !== 4'b1110) begin
      errors++; $display("FAIL ghost_scan got n=%0d held=%b col=%b want 0/0/1110", n_pulse, w_held, w_col); end
    keys = 16'd0;
  endtask

  task automatic test_reset_mid_hold();
    keys = 16'd0; keys[6] = 1'b1;
    do_reset();
    run_to(40);
    checks++; if (w_held !== 1'b1) begin errors++; $display("FAIL rmh_held got %b want 1", w_held); end
    rst = 1'b1;
    tick();
    checks++; if (w_col !== 4'b1110 || w_held !== 1'b0 || w_key !== 4'd0) begin
      errors++; $display("FAIL rmh_after got col=%b held=%b key=%0d want 1110/0/0", w_col, w_held, w_key); end
    rst = 1'b0;
    keys = 16'd0;
    cyc = 0; n_pulse = 0; prev_pulse = 1'b0;
    run_to(40);
    checks++; if (n_pulse !== 0) begin errors++; $display("FAIL rmh_discard got %0d pulses want 0", n_pulse); end
    keys[6] = 1'b1;
    run_to(140);
    checks++; if (n_pulse !== 1 || pulse_key[0] !== 4'd7 || pulse_cyc[0] !== 60) begin
      errors++; $display("FAIL rmh_repress got n=%0d key=%0d at %0d want 1 key=7 at 60",
                         n_pulse, pulse_key[0], pulse_cyc[0]); end
    keys = 16'd0;
    run_to(180);
  endtask

  // Key 4 (row 1, col 0): sampled at cycle 3, EMIT at 20, held to cycle 220.
  task automatic test_long_hold();
    keys = 16'd0; keys[4] = 1'b1;
    do_reset();
    run_to(220);
    keys = 16'd0;
    run_to(260);
`ifdef KEYPAD_AUTOREPEAT_EN
    checks++; if (n_pulse !== 4) begin errors++; $display("FAIL repeat_count got %0d want 4", n_pulse); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pulse_cyc[i] !== 20 + 64*i || pulse_key[i] !== 4'd5) begin
        errors++; $display("FAIL repeat_pulse%0d got key=%0d at %0d want 5 at %0d", i, pulse_key[i], pulse_cyc[i], 20 + 64*i); end
    end
`else
    checks++; if (n_pulse !== 1 || pulse_cyc[0] !== 20 || pulse_key[0] !== 4'd5) begin
      errors++; $display("FAIL hold_single got n=%0d key=%0d at %0d want 1 key=5 at 20", n_pulse, pulse_key[0], pulse_cyc[0]); end
`endif
  endtask

  // Release visible in row_s from cycle 21, rescan at 37, re-press sampled at 40.
  task automatic test_back_to_back();
    keys = 16'd0; keys[4] = 1'b1;
    do_reset();
    run_to(19);
    keys = 16'd0;
    run_to(36);
    checks++; if (w_held !== 1'b1) begin errors++; $display("FAIL b2b_held got %b want 1", w_held); end
    keys[4] = 1'b1;
    run_to(37);
    checks++; if (w_held !== 1'b0 || w_col !== 4'b1110) begin
      errors++; $display("FAIL b2b_rescan got held=%b col=%b want 0/1110", w_held, w_col); end
    run_to(80);
    keys = 16'd0;
    checks++; if (n_pulse !== 2 || pulse_cyc[0] !== 20 || pulse_cyc[1] !== 57 || pulse_key[1] !== 4'd5) begin
      errors++; $display("FAIL b2b_spacing got n=%0d at %0d,%0d key=%0d want 2 at 20,57 key=5",
                         n_pulse, pulse_cyc[0], pulse_cyc[1], pulse_key[1]); end
    run_to(110);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_clear_key();
    test_ghosting();
    test_reset_mid_hold();
    test_long_hold();
    test_back_to_back();
    checks++; if (viol !== 0) begin errors++; $display("FAIL pulse_rules got %0d violations want 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
